// File: rtl/de1_rst_seq.sv
// de1_rst_seq: staged reset sequencer for the DE1 board, releasing PLL, system, SDRAM, then CPU resets.
// Optional KEY0 push-button resequencing is compiled in when DE1_RST_SEQ_KEY_EN is defined.
module de1_rst_seq #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PLL_RST_CYC = 16,
    parameter int unsigned SETTLE_CYC  = 1024,
    parameter int unsigned SDRAM_CYC   = 5000,
    parameter int unsigned CPU_CYC     = 256,
    parameter int unsigned CNT_W       = 16
) (
    input  logic       CLOCK50,
    input  logic       RST,
    input  logic       PLL_LOCKED,
`ifdef DE1_RST_SEQ_KEY_EN
    input  logic       KEY0,
`endif
    output logic       PLL_RST,
    output logic       SYS_RST,
    output logic       SDRAM_RST,
    output logic       CPU_RST,
    output logic       READY,
    output logic [2:0] STATE
);

    localparam logic [2:0] S_PLL_RESET  = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK  = 3'd1;
    localparam logic [2:0] S_SETTLE     = 3'd2;
    localparam logic [2:0] S_SDRAM_INIT = 3'd3;
    localparam logic [2:0] S_CPU_HOLD   = 3'd4;
    localparam logic [2:0] S_RUN        = 3'd5;

    localparam logic [CNT_W-1:0] LD_PLL    = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0] LD_SETTLE = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] LD_SDRAM  = CNT_W'(SDRAM_CYC - 1);
    localparam logic [CNT_W-1:0] LD_CPU    = CNT_W'(CPU_CYC - 1);

    logic [SYNC_STAGES-1:0] lock_sync;
    logic                   lock_s;
    logic                   key_fall;
    logic [2:0]             state;
    logic [2:0]             state_n;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_n;
    logic [4:0]             outs_n;

    always_ff @(posedge CLOCK50) begin
        if (RST) begin
            lock_sync <= '0;
        end else begin
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], PLL_LOCKED};
        end
    end

    assign lock_s = lock_sync[SYNC_STAGES-1];

`ifdef DE1_RST_SEQ_KEY_EN
    localparam logic [15:0] DB_LAST = 16'd49999;

    logic [1:0]  key_sync;
    logic        key_db;
    logic [15:0] db_cnt;

    // Debounced level only flips after 50000 consecutive samples that differ from it.
    always_ff @(posedge CLOCK50) begin
        if (RST) begin
            key_sync <= '1;
            key_db   <= 1'b1;
            db_cnt   <= '0;
        end else begin
            key_sync <= {key_sync[0], KEY0};
            if (key_sync[1] == key_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                key_db <= key_sync[1];
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 16'd1;
            end
        end
    end

    assign key_fall = key_db && !key_sync[1] && (db_cnt == DB_LAST);
`else
    assign key_fall = 1'b0;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
        case (state)
            S_PLL_RESET: begin
                if (cnt == '0) state_n = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_n = S_SETTLE;
                    cnt_n   = LD_SETTLE;
                end
            end
            S_SETTLE: begin
                if (!lock_s) begin
                    state_n = S_PLL_RESET;
                    cnt_n   = LD_PLL;
                end else if (cnt == '0) begin
                    state_n = S_SDRAM_INIT;
                    cnt_n   = LD_SDRAM;
                end
            end
            S_SDRAM_INIT: begin
                if (!lock_s) begin
                    state_n = S_PLL_RESET;
                    cnt_n   = LD_PLL;
                end else if (cnt == '0) begin
                    state_n = S_CPU_HOLD;
                    cnt_n   = LD_CPU;
                end
            end
            S_CPU_HOLD: begin
                if (!lock_s) begin
                    state_n = S_PLL_RESET;
                    cnt_n   = LD_PLL;
                end else if (cnt == '0) begin
                    state_n = S_RUN;
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    state_n = S_PLL_RESET;
                    cnt_n   = LD_PLL;
                end
            end
            default: begin
                state_n = S_PLL_RESET;
                cnt_n   = LD_PLL;
            end
        endcase
        if (key_fall) begin
            state_n = S_PLL_RESET;
            cnt_n   = LD_PLL;
        end
    end

    // Outputs are decoded from the next state so they register on the same edge as the state.
    always_comb begin
        outs_n = 5'b11110;
        case (state_n)
            S_WAIT_LOCK, S_SETTLE: outs_n = 5'b01110;
            S_SDRAM_INIT:          outs_n = 5'b00110;
            S_CPU_HOLD:            outs_n = 5'b00010;
            S_RUN:                 outs_n = 5'b00001;
            default:               outs_n = 5'b11110;
        endcase
    end

    always_ff @(posedge CLOCK50) begin
        if (RST) begin
            state     <= S_PLL_RESET;
            cnt       <= LD_PLL;
            PLL_RST   <= 1'b1;
            SYS_RST   <= 1'b1;
            SDRAM_RST <= 1'b1;
            CPU_RST   <= 1'b1;
            READY     <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            PLL_RST   <= outs_n[4];
            SYS_RST   <= outs_n[3];
            SDRAM_RST <= outs_n[2];
            CPU_RST   <= outs_n[1];
            READY     <= outs_n[0];
        end
    end

    assign STATE = state;

endmodule

// File: tb/tb_de1_rst_seq.sv
// Bench for de1_rst_seq: table of {RST, PLL_LOCKED, cycles, expected state/outputs} rows,
// expectations queued at drive time and compared after each rising edge.
module tb_de1_rst_seq;

    logic       CLOCK50;
    logic       RST;
    logic       PLL_LOCKED;
    logic       PLL_RST;
    logic       SYS_RST;
    logic       SDRAM_RST;
    logic       CPU_RST;
    logic       READY;
    logic [2:0] STATE;
    logic [4:0] outs;

    localparam logic [4:0] O_PR = 5'b11110;
    localparam logic [4:0] O_WL = 5'b01110;
    localparam logic [4:0] O_SE = 5'b01110;
    localparam logic [4:0] O_SD = 5'b00110;
    localparam logic [4:0] O_CH = 5'b00010;
    localparam logic [4:0] O_RN = 5'b00001;

    typedef struct {
        logic        rst;
        logic        lock;
        int unsigned n;
        logic [2:0]  st;
        logic [4:0]  outs;
    } vec_t;

    typedef struct {
        int unsigned row;
        logic [2:0]  st;
        logic [4:0]  outs;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    exp_t e;
    exp_t e_push;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc;
    bit   got;

    de1_rst_seq dut (
        .CLOCK50    (CLOCK50),
        .RST        (RST),
        .PLL_LOCKED (PLL_LOCKED),
        .PLL_RST    (PLL_RST),
        .SYS_RST    (SYS_RST),
        .SDRAM_RST  (SDRAM_RST),
        .CPU_RST    (CPU_RST),
        .READY      (READY),
        .STATE      (STATE)
    );

    assign outs = {PLL_RST, SYS_RST, SDRAM_RST, CPU_RST, READY};

    initial CLOCK50 = 1'b0;
    always #5 CLOCK50 = ~CLOCK50;

    function automatic void add(input logic rst, input logic lock, input int unsigned n,
                                input logic [2:0] st, input logic [4:0] o);
        vec_t v;
        v.rst  = rst;
        v.lock = lock;
        v.n    = n;
        v.st   = st;
        v.outs = o;
        tbl.push_back(v);
    endfunction

    always @(posedge CLOCK50) begin
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (STATE !== e.st || outs !== e.outs) begin
                n_bad++;
                $display("FAIL row%0d @%0t: got STATE=%0d outs=%b, expected STATE=%0d outs=%b",
                         e.row, $time, STATE, outs, e.st, e.outs);
            end
        end
    end

    initial begin
        RST        = 1'b1;
        PLL_LOCKED = 1'b0;

        // Reset with no lock: PLL_RST held 16 cycles, then parked in WAIT_LOCK.
        add(1, 0, 5,   0, O_PR);
        add(0, 0, 15,  0, O_PR);
        add(0, 0, 200, 1, O_WL);
        // Normal bring-up: lock 10 cycles into WAIT_LOCK, 2 sync cycles, then the counted stages.
        add(1, 0, 5,    0, O_PR);
        add(0, 0, 15,   0, O_PR);
        add(0, 0, 10,   1, O_WL);
        add(0, 1, 2,    1, O_WL);
        add(0, 1, 1024, 2, O_SE);
        add(0, 1, 5000, 3, O_SD);
        add(0, 1, 256,  4, O_CH);
        add(0, 1, 20,   5, O_RN);
        // One-cycle lock glitch mid SDRAM_INIT resequences everything.
        add(1, 1, 1,    0, O_PR);
        add(0, 1, 15,   0, O_PR);
        add(0, 1, 1,    1, O_WL);
        add(0, 1, 1024, 2, O_SE);
        add(0, 1, 2500, 3, O_SD);
        add(0, 0, 1,    3, O_SD);
        add(0, 1, 1,    3, O_SD);
        add(0, 1, 16,   0, O_PR);
        add(0, 1, 1,    1, O_WL);
        add(0, 1, 1024, 2, O_SE);
        add(0, 1, 5000, 3, O_SD);
        add(0, 1, 256,  4, O_CH);
        add(0, 1, 20,   5, O_RN);
        // RST pulse in RUN, then a second pulse inside PLL_RESET restarts the 16-cycle count.
        add(1, 1, 1,    0, O_PR);
        add(0, 1, 5,    0, O_PR);
        add(1, 1, 1,    0, O_PR);
        add(0, 1, 15,   0, O_PR);
        add(0, 1, 1,    1, O_WL);
        add(0, 1, 1024, 2, O_SE);
        add(0, 1, 5000, 3, O_SD);
        add(0, 1, 256,  4, O_CH);
        add(0, 1, 20,   5, O_RN);
        // Lock loss lands on the same edge SETTLE's count expires: lock loss wins.
        add(1, 1, 1,    0, O_PR);
        add(0, 1, 15,   0, O_PR);
        add(0, 1, 1,    1, O_WL);
        add(0, 1, 1022, 2, O_SE);
        add(0, 0, 2,    2, O_SE);
        add(0, 0, 16,   0, O_PR);
        add(0, 0, 30,   1, O_WL);

        for (int r = 0; r < tbl.size(); r++) begin
            for (int unsigned i = 0; i < tbl[r].n; i++) begin
                @(negedge CLOCK50);
                RST        = tbl[r].rst;
                PLL_LOCKED = tbl[r].lock;
                e_push.row  = r;
                e_push.st   = tbl[r].st;
                e_push.outs = tbl[r].outs;
                exp_q.push_back(e_push);
            end
        end
        @(negedge CLOCK50);

        // Reset-to-READY latency with lock already present: 16 + 1 + 1024 + 5000 + 256 edges.
        RST        = 1'b1;
        PLL_LOCKED = 1'b1;
        @(negedge CLOCK50);
        RST = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (cyc < 10000 && !got) begin
            @(posedge CLOCK50);
            #1;
            cyc++;
            if (READY === 1'b1) got = 1'b1;
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL ready_latency: READY not seen within %0d cycles, required at cycle 6297", cyc);
        end else if (cyc != 6297) begin
            n_bad++;
            $display("FAIL ready_latency: READY rose at cycle %0d, required 6297", cyc);
        end
        n_cmp++;
        if (STATE !== 3'd5 || outs !== O_RN) begin
            n_bad++;
            $display("FAIL ready_outputs: got STATE=%0d outs=%b, expected STATE=5 outs=%b",
                     STATE, outs, O_RN);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run exceeded its time limit at %0t", $time);
        $fatal(1);
    end

endmodule
